// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the serial shift sequencer: state encoding,
// default word length and the bit-order encoding carried by lsb_first.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Word-in / bit-out bus of the shift sequencer. The producer side
// (master) drives the word handshake and flush; the controller (slave)
// returns ready, the qualified serial bit and status.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = shift_pkg::DEFAULT_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             lsb_first;
  logic             flush;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data, lsb_first, flush,
    input  in_ready, ser_out, ser_valid, busy, done
  );

  modport slave (
    input  in_valid, in_data, lsb_first, flush,
    output in_ready, ser_out, ser_valid, busy, done
  );
endinterface

// File: rtl/shift_seq_ctrl_piso.sv
// Parallel-load shift register. Pure datapath: load wins over shift, and
// dir selects which end the data moves toward. The two taps expose the
// bit that sits one position in from each end, i.e. the bit that the
// controller presents on the same edge the register shifts.
module piso_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             shift_en,
  input  logic             dir,
  input  logic [WIDTH-1:0] din,
  output logic             next_lsb,
  output logic             next_msb
);

  logic [WIDTH-1:0] q;

  // Load a fresh word or advance it one position toward the output end.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift_en) begin
      if (dir == LSB_FIRST) q <= {1'b0, q[WIDTH-1:1]};
      else                  q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign next_lsb = q[1];
  assign next_msb = q[WIDTH-2];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serial shift sequencer: accepts a word on a valid/ready handshake and
// presents it as WIDTH qualified serial bits, then pulses done.
//
// state | meaning
// IDLE  | ready for a word; flush blocks acceptance
// SHIFT | presenting bits, cnt = bits already presented
// DONE  | one-cycle done pulse, then back to IDLE
//
// The first bit is taken straight from in_data on the accept edge so it
// appears with no extra latency; the remaining bits come from piso_reg.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic             clock,
  input logic             clear,
  shift_seq_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             order;
  logic             accept;
  logic             last_bit;
  logic             shift_en;
  logic             first_bit;
  logic             next_bit;
  logic             next_lsb;
  logic             next_msb;

  assign accept    = (state == IDLE) && bus.in_ready && bus.in_valid && !bus.flush;
  assign last_bit  = (cnt == LAST);
  assign shift_en  = (state == SHIFT) && !bus.flush && !last_bit;
  assign first_bit = (bus.lsb_first == LSB_FIRST) ? bus.in_data[0] : bus.in_data[WIDTH-1];
  assign next_bit  = (order == LSB_FIRST) ? next_lsb : next_msb;

  piso_reg #(.WIDTH(WIDTH)) u_piso (
    .clock    (clock),
    .clear    (clear),
    .load     (accept),
    .shift_en (shift_en),
    .dir      (order),
    .din      (bus.in_data),
    .next_lsb (next_lsb),
    .next_msb (next_msb)
  );

  // Sequencing FSM with bit counter and registered handshake/serial outputs.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state         <= IDLE;
      cnt           <= '0;
      order         <= MSB_FIRST;
      bus.in_ready  <= 1'b0;
      bus.ser_out   <= 1'b0;
      bus.ser_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            order         <= bus.lsb_first;
            bus.ser_out   <= first_bit;
            bus.ser_valid <= 1'b1;
            bus.busy      <= 1'b1;
            bus.in_ready  <= 1'b0;
            cnt           <= CNT_W'(1);
            state         <= SHIFT;
          end else begin
            bus.in_ready  <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.flush) begin
            bus.ser_out   <= 1'b0;
            bus.ser_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
            cnt           <= '0;
            state         <= IDLE;
          end else if (last_bit) begin
            bus.ser_out   <= 1'b0;
            bus.ser_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            cnt           <= '0;
            state         <= DONE;
          end else begin
            bus.ser_out   <= next_bit;
            cnt           <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          bus.done     <= 1'b0;
          bus.in_ready <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
